clock_divider_multi: RTL and testbench

//  Multi-channel programmable clock divider / tick generator for the alarm-clock datapath.
//  One shared counter engine per channel produces a one-cycle tick every DIV clocks and a
//  50%-duty toggle output (period 2*DIV). Runtime divisor writes are glitch-free: they load
//  at the channel's next wrap. Typical use: 1 Hz timekeeping, display scan, buzzer tone.

---
 rtl/clock_divider_multi.sv | 129 ++++++++++++
 tb/tb_clock_divider_multi.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable tick / 50%-duty clock divider with glitch-free divisor reload.
// Optional CLKDIV_SYNC_CLR_EN adds a per-channel synchronous clear input (sync_clr).
module clock_divider_multi #(
  parameter  int NCH         = 4,
  parameter  int WIDTH       = 26,
  parameter  int DEFAULT_DIV = 50000000,
  localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_div,
`ifdef CLKDIV_SYNC_CLR_EN
  input  logic [NCH-1:0]   sync_clr,
`endif
  output logic [NCH-1:0]   pend,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_out
);

  logic [WIDTH-1:0] count_q  [NCH];
  logic [WIDTH-1:0] count_d  [NCH];
  logic [WIDTH-1:0] active_q [NCH];
  logic [WIDTH-1:0] active_d [NCH];
  logic [WIDTH-1:0] shadow_q [NCH];
  logic [WIDTH-1:0] shadow_d [NCH];
  logic [WIDTH-1:0] last     [NCH];
  logic [NCH-1:0]   pend_q, pend_d;
  logic [NCH-1:0]   tick_q, tick_d;
  logic [NCH-1:0]   clk_out_q, clk_out_d;
  logic [NCH-1:0]   wr_hit, wrap, clr;

`ifdef CLKDIV_SYNC_CLR_EN
  assign clr = sync_clr;
`else
  assign clr = '0;
`endif

  // A divisor of 0 behaves as 1, so the terminal count is 0 in both cases.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      last[i]   = (active_q[i] == '0) ? '0 : active_q[i] - 1'b1;
      wr_hit[i] = wr_en && (32'(wr_ch) == i);
      wrap[i]   = en[i] && (count_q[i] == last[i]);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      count_d[i]   = count_q[i];
      active_d[i]  = active_q[i];
      shadow_d[i]  = shadow_q[i];
      pend_d[i]    = pend_q[i];
      tick_d[i]    = 1'b0;
      clk_out_d[i] = clk_out_q[i];

      if (clr[i]) begin
        // Pending value loads first; a same-cycle write then re-arms the shadow.
        count_d[i]   = '0;
        clk_out_d[i] = 1'b0;
        if (pend_q[i]) active_d[i] = shadow_q[i];
        pend_d[i] = 1'b0;
        if (wr_hit[i]) begin
          shadow_d[i] = wr_div;
          pend_d[i]   = 1'b1;
        end
      end else if (en[i]) begin
        if (wrap[i]) begin
          count_d[i]   = '0;
          tick_d[i]    = 1'b1;
          clk_out_d[i] = ~clk_out_q[i];
          if (wr_hit[i]) begin
            active_d[i] = wr_div;
            shadow_d[i] = wr_div;
            pend_d[i]   = 1'b0;
          end else if (pend_q[i]) begin
            active_d[i] = shadow_q[i];
            pend_d[i]   = 1'b0;
          end
        end else begin
          count_d[i] = count_q[i] + 1'b1;
          if (wr_hit[i]) begin
            shadow_d[i] = wr_div;
            pend_d[i]   = 1'b1;
          end
        end
      end else begin
        if (pend_q[i]) begin
          count_d[i]  = '0;
          active_d[i] = wr_hit[i] ? wr_div : shadow_q[i];
          shadow_d[i] = wr_hit[i] ? wr_div : shadow_q[i];
          pend_d[i]   = 1'b0;
        end else if (wr_hit[i]) begin
          shadow_d[i] = wr_div;
          pend_d[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        count_q[i]  <= '0;
        active_q[i] <= WIDTH'(DEFAULT_DIV);
        shadow_q[i] <= WIDTH'(DEFAULT_DIV);
      end
      pend_q    <= '0;
      tick_q    <= '0;
      clk_out_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        count_q[i]  <= count_d[i];
        active_q[i] <= active_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign pend    = pend_q;
  assign tick    = tick_q;
  assign clk_out = clk_out_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi against a cycle-level behavioural model.
module tb_clock_divider_multi;
  localparam int NCH = 4;
  localparam int WIDTH = 8;
  localparam int DDIV = 5;
  localparam int CHW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NCH-1:0]   en = '0;
  logic             wr_en = 1'b0;
  logic [CHW-1:0]   wr_ch = '0;
  logic [WIDTH-1:0] wr_div = '0;
  logic [NCH-1:0]   pend, tick, clk_out;
`ifdef CLKDIV_SYNC_CLR_EN
  logic [NCH-1:0]   sync_clr = '0;
`endif

  int m_cnt [NCH];
  int m_per [NCH];
  int m_shd [NCH];
  bit m_pnd [NCH];
  bit m_tk  [NCH];
  bit m_co  [NCH];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  clock_divider_multi #(.NCH(NCH), .WIDTH(WIDTH), .DEFAULT_DIV(DDIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
`ifdef CLKDIV_SYNC_CLR_EN
    .sync_clr(sync_clr),
`endif
    .pend(pend), .tick(tick), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_per[i] = DDIV; m_shd[i] = DDIV;
      m_pnd[i] = 0; m_tk[i] = 0; m_co[i] = 0;
    end
  endtask

  // Spec rules per channel: period = max(div,1); loads only where the count restarts.
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit hit;
      bit clr;
      int period;
      hit = wr_en && (int'(wr_ch) == i);
      clr = 0;
`ifdef CLKDIV_SYNC_CLR_EN
      clr = sync_clr[i];
`endif
      period = (m_per[i] < 1) ? 1 : m_per[i];
      m_tk[i] = 0;
      if (clr) begin
        if (m_pnd[i]) m_per[i] = m_shd[i];
        m_pnd[i] = 0; m_cnt[i] = 0; m_co[i] = 0;
        if (hit) begin m_shd[i] = wr_div; m_pnd[i] = 1; end
      end else if (en[i]) begin
        m_cnt[i] = (m_cnt[i] + 1) % period;
        if (m_cnt[i] == 0) begin
          m_tk[i] = 1; m_co[i] = !m_co[i];
          if (hit) m_per[i] = wr_div;
          else if (m_pnd[i]) m_per[i] = m_shd[i];
          m_pnd[i] = 0;
        end else if (hit) begin
          m_shd[i] = wr_div; m_pnd[i] = 1;
        end
      end else if (m_pnd[i]) begin
        m_cnt[i] = 0;
        m_per[i] = hit ? int'(wr_div) : m_shd[i];
        m_pnd[i] = 0;
      end else if (hit) begin
        m_shd[i] = wr_div; m_pnd[i] = 1;
      end
    end
  endtask

  function automatic logic [3*NCH-1:0] model_vec();
    logic [3*NCH-1:0] v;
    for (int i = 0; i < NCH; i++) begin
      v[2*NCH+i] = m_tk[i];
      v[NCH+i]   = m_co[i];
      v[i]       = m_pnd[i];
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int first;
    int nt;
    en = '0;
    rst_n = 1'b0;
    #2;
    model_reset();
    checks++;
    if ({tick, clk_out, pend} !== '0) begin
      failures++; $display("FAIL reset_state got=%h exp=0", {tick, clk_out, pend});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = '1;
    first = -1; nt = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      checks++;
      if ({tick, clk_out, pend} !== model_vec()) begin
        failures++; $display("FAIL reset_run cyc=%0d got=%h exp=%h", cyc, {tick, clk_out, pend}, model_vec());
      end
      if (tick == 4'hF) nt++;
      if (first < 0 && tick[0]) first = k;
    end
    checks++;
    if (first !== 5) begin failures++; $display("FAIL first_tick got=%0d exp=5", first); end
    checks++;
    if (nt !== 5) begin failures++; $display("FAIL tick_count got=%0d exp=5", nt); end
  endtask

  task automatic test_midwrite();
    int nt;
    do_reset();
    en = '1;
    step(); step();
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 8'd3;
    step();
    wr_en = 1'b0;
    checks++;
    if (pend[1] !== 1'b1) begin failures++; $display("FAIL mid_pend got=%b exp=1", pend[1]); end
    nt = 0;
    for (int e = 4; e <= 23; e++) begin
      step();
      checks++;
      if ({tick, clk_out, pend} !== model_vec()) begin
        failures++; $display("FAIL midwrite cyc=%0d got=%h exp=%h", cyc, {tick, clk_out, pend}, model_vec());
      end
      if (tick[1]) nt++;
    end
    checks++;
    if (nt !== 7) begin failures++; $display("FAIL mid_ticks got=%0d exp=7", nt); end
  endtask

  task automatic test_div_zero();
    int ones;
    int tog;
    logic prev;
    wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd0;
    step();
    wr_en = 1'b0;
    ones = 0; tog = 0; prev = clk_out[2];
    for (int k = 0; k < 15; k++) begin
      step();
      checks++;
      if ({tick, clk_out, pend} !== model_vec()) begin
        failures++; $display("FAIL div_zero cyc=%0d got=%h exp=%h", cyc, {tick, clk_out, pend}, model_vec());
      end
      if (k >= 10) begin
        if (tick[2]) ones++;
        if (clk_out[2] != prev) tog++;
      end
      prev = clk_out[2];
    end
    checks++;
    if (ones !== 5 || tog !== 5) begin
      failures++; $display("FAIL div_zero_rate got=%0d/%0d exp=5/5", ones, tog);
    end
  endtask

  task automatic test_en_hold();
    bit found;
    bit bad;
    logic held;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (m_cnt[3] == 3) found = 1;
      else step();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL en_hold_sync got=timeout exp=count3"); end
    en[3] = 1'b0;
    held = clk_out[3];
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      checks++;
      if ({tick, clk_out, pend} !== model_vec()) begin
        failures++; $display("FAIL en_hold cyc=%0d got=%h exp=%h", cyc, {tick, clk_out, pend}, model_vec());
      end
      if (tick[3] !== 1'b0 || clk_out[3] !== held) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL en_hold_frozen got=moving exp=frozen"); end
    en[3] = 1'b1;
    step();
    checks++;
    if (tick[3] !== 1'b0) begin failures++; $display("FAIL resume_early got=%b exp=0", tick[3]); end
    step();
    checks++;
    if (tick[3] !== 1'b1) begin failures++; $display("FAIL resume_tick got=%b exp=1", tick[3]); end
  endtask

  task automatic test_wrap_write();
    bit found;
    int per;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (m_cnt[0] == DDIV - 1) found = 1;
      else step();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL wrap_sync got=timeout exp=count4"); end
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd7;
    step();
    wr_en = 1'b0;
    checks++;
    if (pend[0] !== 1'b0 || tick[0] !== 1'b1) begin
      failures++; $display("FAIL wrap_bypass got=pend%b/tick%b exp=pend0/tick1", pend[0], tick[0]);
    end
    per = -1;
    for (int k = 1; k <= 20 && per < 0; k++) begin
      step();
      checks++;
      if ({tick, clk_out, pend} !== model_vec()) begin
        failures++; $display("FAIL wrap_run cyc=%0d got=%h exp=%h", cyc, {tick, clk_out, pend}, model_vec());
      end
      if (tick[0]) per = k;
    end
    checks++;
    if (per !== 7) begin failures++; $display("FAIL wrap_period got=%0d exp=7", per); end
    step(); step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({tick, clk_out, pend} !== '0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", {tick, clk_out, pend});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = '1;
    per = -1;
    for (int k = 1; k <= 10 && per < 0; k++) begin
      step();
      checks++;
      if ({tick, clk_out, pend} !== model_vec()) begin
        failures++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, {tick, clk_out, pend}, model_vec());
      end
      if (tick[0]) per = k;
    end
    checks++;
    if (per !== DDIV) begin failures++; $display("FAIL reset_div got=%0d exp=%0d", per, DDIV); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      en = NCH'($urandom);
      if ($urandom_range(0, 9) < 7) en = '1;
      wr_en = ($urandom_range(0, 3) == 0);
      wr_ch = CHW'($urandom);
      wr_div = WIDTH'($urandom_range(0, 9));
`ifdef CLKDIV_SYNC_CLR_EN
      sync_clr = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
`endif
      step();
      checks++;
      if ({tick, clk_out, pend} !== model_vec()) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {tick, clk_out, pend}, model_vec());
      end
    end
    wr_en = 1'b0;
`ifdef CLKDIV_SYNC_CLR_EN
    sync_clr = '0;
`endif
  endtask

`ifdef CLKDIV_SYNC_CLR_EN
  task automatic test_sync_clr();
    bit bad;
    do_reset();
    en = 4'b0001;
    step(); step();
    en = '1;
    step();
    sync_clr = 4'b0011;
    step();
    sync_clr = '0;
    checks++;
    if (clk_out[1:0] !== 2'b00 || tick[1:0] !== 2'b00) begin
      failures++; $display("FAIL sync_clr_state got=%b/%b exp=00/00", clk_out[1:0], tick[1:0]);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if ({tick, clk_out, pend} !== model_vec()) begin
        failures++; $display("FAIL sync_clr cyc=%0d got=%h exp=%h", cyc, {tick, clk_out, pend}, model_vec());
      end
      if (tick[0] !== tick[1]) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL sync_align got=unaligned exp=aligned"); end
  endtask
`endif

  initial begin
    test_reset();
    test_midwrite();
    test_div_zero();
    test_en_hold();
    test_wrap_write();
    test_random();
`ifdef CLKDIV_SYNC_CLR_EN
    test_sync_clr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
